depatchifier: RTL

Reassembles a ViT image from a patch-ordered pixel stream. It is the inverse of the patchification stage: it accepts one pixel per beat over a valid/ready interface, in patch-major, position-minor order. Each pixel is scattered into a full-image register buffer, and the completed image is held for a downstream consumer. It sits on the output side of the patch pipeline, where per-patch results are returned to image space.

---
 rtl/vit_pkg.sv | 29 ++
 rtl/patch_addr_gen.sv | 60 ++++++
 rtl/depatchifier.sv | 94 +++++++++
 3 files changed

// File: rtl/vit_pkg.sv
// Shared ViT pipeline definitions: pixel format, image/patch geometry and the
// frame-level state encoding used by both the patchifier and the depatchifier.
package vit_pkg;

    localparam int CHANNEL_SIZE      = 8;
    localparam int NUM_CHANNELS      = 3;
    localparam int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS;

    localparam int IMG_WIDTH         = 64;
    localparam int IMG_HEIGHT        = 64;
    localparam int PATCH_SIZE        = 16;
    localparam int PATCH_SIZE_LOG2   = 4;
    localparam int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE;
    localparam int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE);
    localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;

    // 2'b01 is the busy state: PROCESSING in the patchifier, RECEIVING here.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RECEIVING = 2'b01,
        ST_DONE      = 2'b10
    } vit_state_e;

    // Counter width that stays legal when the range collapses to a single value.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/patch_addr_gen.sv
// Patch-major pixel counters that map (patch_idx, pos_idx) to an image
// (row, col) coordinate; shared by the patchifier and depatchifier.
module patch_addr_gen #(
    parameter int IMG_WIDTH         = vit_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT        = vit_pkg::IMG_HEIGHT,
    parameter int PATCH_SIZE        = vit_pkg::PATCH_SIZE,
    parameter int PATCH_SIZE_LOG2   = vit_pkg::PATCH_SIZE_LOG2,
    parameter int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE,
    parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE,
    parameter int ROW_W             = vit_pkg::clog2_min1(IMG_WIDTH),
    parameter int COL_W             = vit_pkg::clog2_min1(IMG_HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             is_final
);

    localparam int POS_W    = vit_pkg::clog2_min1(PATCH_VECTOR_SIZE);
    localparam int PATCH_W  = vit_pkg::clog2_min1(TOTAL_NUM_PATCHES);
    localparam int PIR_LOG2 = $clog2(PATCHES_IN_ROW);

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(PATCH_VECTOR_SIZE - 1);
    localparam logic [PATCH_W-1:0] PATCH_LAST = PATCH_W'(TOTAL_NUM_PATCHES - 1);

    logic [POS_W-1:0]   pos_idx;
    logic [PATCH_W-1:0] patch_idx;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_idx   <= '0;
            patch_idx <= '0;
        end else if (clear) begin
            pos_idx   <= '0;
            patch_idx <= '0;
        end else if (advance) begin
            if (pos_idx == POS_LAST) begin
                pos_idx   <= '0;
                patch_idx <= (patch_idx == PATCH_LAST) ? '0 : patch_idx + 1'b1;
            end else begin
                pos_idx   <= pos_idx + 1'b1;
            end
        end
    end

    // Patch grid coordinate selects the tile; pos_idx walks raster order inside it.
    assign row = ROW_W'((int'(patch_idx) >> PIR_LOG2) * PATCH_SIZE
                        + (int'(pos_idx) >> PATCH_SIZE_LOG2));
    assign col = COL_W'((int'(patch_idx) & (PATCHES_IN_ROW - 1)) * PATCH_SIZE
                        + (int'(pos_idx) & (PATCH_SIZE - 1)));

    assign is_final = (pos_idx == POS_LAST) && (patch_idx == PATCH_LAST);

endmodule

// File: rtl/depatchifier.sv
// Scatters a patch-ordered pixel stream back into a full image register buffer
// and holds the completed frame until the consumer takes it.
module depatchifier #(
    parameter int CHANNEL_SIZE      = vit_pkg::CHANNEL_SIZE,
    parameter int NUM_CHANNELS      = vit_pkg::NUM_CHANNELS,
    parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int IMG_WIDTH         = vit_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT        = vit_pkg::IMG_HEIGHT,
    parameter int PATCH_SIZE        = vit_pkg::PATCH_SIZE,
    parameter int PATCH_SIZE_LOG2   = vit_pkg::PATCH_SIZE_LOG2,
    parameter int PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE,
    parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    input  logic                   in_last,
    input  logic                   output_taken,
    output logic [1:0]             state,
    output logic                   error,
    output logic [PIXEL_WIDTH-1:0] image_out [IMG_WIDTH][IMG_HEIGHT]
);

    localparam int ROW_W = vit_pkg::clog2_min1(IMG_WIDTH);
    localparam int COL_W = vit_pkg::clog2_min1(IMG_HEIGHT);

    vit_pkg::vit_state_e state_q, state_d;

    logic             accept;
    logic             start;
    logic             is_final;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    assign in_ready = (state_q == vit_pkg::ST_RECEIVING);
    assign accept   = in_valid && in_ready;
    assign start    = (state_q == vit_pkg::ST_IDLE) && en;
    assign state    = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= vit_pkg::ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: next state defaults to the current state before the case, so no
    // path leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            vit_pkg::ST_IDLE:      if (en)                  state_d = vit_pkg::ST_RECEIVING;
            vit_pkg::ST_RECEIVING: if (accept && is_final)  state_d = vit_pkg::ST_DONE;
            vit_pkg::ST_DONE:      if (output_taken)        state_d = vit_pkg::ST_IDLE;
            default:                                        state_d = vit_pkg::ST_IDLE;
        endcase
    end

    // A stray in_last, or a missing one on the counted final beat, marks the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            error <= 1'b0;
        else if (start)                       error <= 1'b0;
        else if (accept && (in_last != is_final)) error <= 1'b1;
    end

    patch_addr_gen #(
        .IMG_WIDTH        (IMG_WIDTH),
        .IMG_HEIGHT       (IMG_HEIGHT),
        .PATCH_SIZE       (PATCH_SIZE),
        .PATCH_SIZE_LOG2  (PATCH_SIZE_LOG2),
        .PATCHES_IN_ROW   (PATCHES_IN_ROW),
        .TOTAL_NUM_PATCHES(TOTAL_NUM_PATCHES),
        .PATCH_VECTOR_SIZE(PATCH_VECTOR_SIZE),
        .ROW_W            (ROW_W),
        .COL_W            (COL_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (start),
        .advance (accept),
        .row     (row),
        .col     (col),
        .is_final(is_final)
    );

    // NOTE: the image buffer has no reset; a full frame rewrites every entry,
    // and leaving it out keeps the storage as plain enabled flops.
    always_ff @(posedge clk) begin
        if (accept) image_out[row][col] <= in_pixel;
    end

endmodule
